// File: rtl/readout_sequencer.sv
// Round-robin readout master: requests a triggered channel, drains WORDS samples
// from its show-ahead FIFO onto a single valid/ready stream, then releases it.
module readout_sequencer #(
    parameter int NCH     = 4,
    parameter int DATA_W  = 12,
    parameter int WORDS   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RUN,
    input  logic [NCH-1:0]        CH_TRIGGERED,
    input  logic [NCH-1:0]        RO_ENABLE,
    output logic [NCH-1:0]        ROREQUEST,
    output logic [NCH-1:0]        RODONE_n,
    input  logic [NCH-1:0]        CH_EMPTY,
    input  logic [NCH*DATA_W-1:0] CH_DATA,
    output logic [NCH-1:0]        CH_RDEN,
    output logic [DATA_W-1:0]     OUT_DATA,
    output logic [3:0]            OUT_CHAN,
    output logic                  OUT_LAST,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int CW = $clog2(WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_READ,
        S_DONE,
        S_DRAIN,
        S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cur_q, cur_d;
    logic [3:0]          ptr_q, ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [NCH-1:0]      rorequest_q, rorequest_d;
    logic [NCH-1:0]      rodone_n_q, rodone_n_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [3:0]          out_chan_q, out_chan_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    // Channel inputs widened to 16 entries so a 4-bit channel index always fits.
    logic [15:0]         trig_ext;
    logic [15:0]         en_ext;
    logic [15:0]         empty_ext;
    logic [DATA_W-1:0]   data_ext [16];
    logic [NCH-1:0]      sel_oh;
    logic [NCH-1:0]      cur_oh;

    logic                found;
    logic [3:0]          sel;
    logic [3:0]          idx;
    logic                rd_en;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ext
            if (gi < NCH) begin : g_ch
                assign trig_ext[gi]  = CH_TRIGGERED[gi];
                assign en_ext[gi]    = RO_ENABLE[gi];
                assign empty_ext[gi] = CH_EMPTY[gi];
                assign data_ext[gi]  = CH_DATA[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign trig_ext[gi]  = 1'b0;
                assign en_ext[gi]    = 1'b0;
                assign empty_ext[gi] = 1'b1;
                assign data_ext[gi]  = '0;
            end
        end

        for (gi = 0; gi < NCH; gi++) begin : g_onehot
            assign sel_oh[gi]  = (sel == 4'(gi));
            assign cur_oh[gi]  = (cur_q == 4'(gi));
            assign CH_RDEN[gi] = rd_en & cur_oh[gi];
        end
    endgenerate

    // First triggered channel at or after the pointer, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < NCH; k++) begin
            idx = 4'((int'(ptr_q) + k) % NCH);
            if (!found && trig_ext[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // A pop is only allowed when the output register is free or being emptied.
    assign rd_en = (state_q == S_READ) && !empty_ext[cur_q] &&
                   (!out_valid_q || OUT_READY) && (count_q < CW'(WORDS));

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        rorequest_d = rorequest_q;
        rodone_n_d  = '1;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (RUN && found) begin
                    cur_d       = sel;
                    rorequest_d = sel_oh;
                    state_d     = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (en_ext[cur_q]) begin
                    rorequest_d = '0;
                    state_d     = S_READ;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rorequest_d = '0;
                    err_d       = 1'b1;
                    state_d     = S_NEXT;
                end
            end
            S_READ: begin
                if (out_valid_q && OUT_READY && out_last_q && (count_q == CW'(WORDS))) begin
                    rodone_n_d = ~cur_oh;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!en_ext[cur_q]) begin
                    state_d = S_NEXT;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                ptr_d   = (cur_q == 4'(NCH - 1)) ? 4'd0 : cur_q + 4'd1;
                count_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rd_en) begin
            out_data_d  = data_ext[cur_q];
            out_chan_d  = cur_q;
            out_valid_d = 1'b1;
            out_last_d  = (count_q == CW'(WORDS - 1));
            count_d     = count_q + 1'b1;
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    // Timeout counter restarts on every state change and saturates otherwise.
    always_comb begin
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT)) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            rorequest_q <= '0;
            rodone_n_q  <= '1;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            rorequest_q <= rorequest_d;
            rodone_n_q  <= rodone_n_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ROREQUEST = rorequest_q;
    assign RODONE_n  = rodone_n_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_CHAN  = out_chan_q;
    assign OUT_LAST  = out_last_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with a behavioural channel/FIFO model
// and a stream monitor; each scenario task checks its own results inline.
module tb_readout_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RUN = 1'b0;
    logic        OUT_READY = 1'b1;
    logic [3:0]  CH_TRIGGERED = 4'h0;
    logic [3:0]  RO_ENABLE, ROREQUEST, RODONE_n, CH_EMPTY, CH_RDEN;
    logic [47:0] CH_DATA;
    logic [11:0] OUT_DATA;
    logic [3:0]  OUT_CHAN;
    logic        OUT_LAST, OUT_VALID, BUSY, ERR;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    readout_sequencer #(.NCH(4), .DATA_W(12), .WORDS(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .RUN(RUN), .CH_TRIGGERED(CH_TRIGGERED),
        .RO_ENABLE(RO_ENABLE), .ROREQUEST(ROREQUEST), .RODONE_n(RODONE_n),
        .CH_EMPTY(CH_EMPTY), .CH_DATA(CH_DATA), .CH_RDEN(CH_RDEN),
        .OUT_DATA(OUT_DATA), .OUT_CHAN(OUT_CHAN), .OUT_LAST(OUT_LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY), .ERR(ERR)
    );

    // Show-ahead FIFO model per channel
    logic [11:0] mem [4][64];
    int          rd_ptr [4] = '{0, 0, 0, 0};
    int          wr_cnt [4] = '{0, 0, 0, 0};

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        assign CH_EMPTY[g]          = (rd_ptr[g] >= wr_cnt[g]);
        assign CH_DATA[g*12 +: 12]  = mem[g][rd_ptr[g][5:0]];
    end

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++)
            if (CH_RDEN[n[1:0]]) rd_ptr[n[1:0]] <= rd_ptr[n[1:0]] + 1;
    end

    // Channel state machine model: enters READOUT one cycle after ROREQUEST,
    // leaves it when RODONE_n is seen low.
    logic [3:0] resp_en = 4'hF;
    logic [3:0] ro_en_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ro_en_q <= 4'h0;
        else begin
            for (int n = 0; n < 4; n++) begin
                if (resp_en[n[1:0]] && ROREQUEST[n[1:0]]) ro_en_q[n[1:0]] <= 1'b1;
                else if (!RODONE_n[n[1:0]])               ro_en_q[n[1:0]] <= 1'b0;
            end
        end
    end
    assign RO_ENABLE = ro_en_q;

    // Monitor, sampled on the falling edge
    int          cyc = 0;
    int          cap_n = 0;
    logic [11:0] cap_data [128];
    logic [3:0]  cap_chan [128];
    logic        cap_last [128];
    int          cap_cyc  [128];
    int          pulses [4], low_cyc [4], req_cyc [4];
    int          pulse_tot = 0;
    int          done_order [16];
    int          rden_viol = 0, oh_viol = 0, stab_viol = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_data = '0;
    logic [3:0]  prev_chan = '0;
    logic        prev_last = 1'b0;
    logic [3:0]  prev_rodone = 4'hF;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (OUT_VALID && OUT_READY && cap_n < 128) begin
                cap_data[cap_n[6:0]] = OUT_DATA;
                cap_chan[cap_n[6:0]] = OUT_CHAN;
                cap_last[cap_n[6:0]] = OUT_LAST;
                cap_cyc[cap_n[6:0]]  = cyc;
                cap_n++;
                $display("word ch=%0d data=%h last=%0d cyc=%0d", OUT_CHAN, OUT_DATA, OUT_LAST, cyc);
            end
            for (int n = 0; n < 4; n++) begin
                if (!RODONE_n[n[1:0]]) begin
                    low_cyc[n[1:0]]++;
                    if (prev_rodone[n[1:0]]) begin
                        pulses[n[1:0]]++;
                        if (pulse_tot < 16) done_order[pulse_tot[3:0]] = n;
                        pulse_tot++;
                    end
                end
                if (ROREQUEST[n[1:0]]) req_cyc[n[1:0]]++;
            end
            if (CH_RDEN != 4'h0 && OUT_VALID && !OUT_READY) rden_viol++;
            if ($countones(ROREQUEST) > 1 || $countones(CH_RDEN) > 1 ||
                $countones(~RODONE_n) > 1 || (ROREQUEST & ~RODONE_n) != 4'h0) oh_viol++;
            if (prev_stall && (!OUT_VALID || OUT_DATA != prev_data ||
                               OUT_CHAN != prev_chan || OUT_LAST != prev_last)) stab_viol++;
        end
        prev_stall  = rst_n && OUT_VALID && !OUT_READY;
        prev_data   = OUT_DATA;
        prev_chan   = OUT_CHAN;
        prev_last   = OUT_LAST;
        prev_rodone = RODONE_n;
    end

    task automatic clear_mon();
        cap_n = 0;
        pulse_tot = 0;
        for (int n = 0; n < 4; n++) begin
            pulses[n[1:0]] = 0; low_cyc[n[1:0]] = 0; req_cyc[n[1:0]] = 0;
        end
    endtask

    task automatic load_fifo(input int ch, input int base, input int n);
        for (int i = 0; i < n; i++)
            mem[ch[1:0]][6'(wr_cnt[ch[1:0]] + i)] = 12'(base + i);
        wr_cnt[ch[1:0]] += n;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_pulses(input int target, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step(1);
            if (pulse_tot >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_cap(input int target, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step(1);
            if (cap_n >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        total++; if (ROREQUEST !== 4'h0) begin bad++; $display("FAIL reset_rorequest got=%h exp=0", ROREQUEST); end
        total++; if (RODONE_n !== 4'hF) begin bad++; $display("FAIL reset_rodone got=%h exp=f", RODONE_n); end
        total++; if (CH_RDEN !== 4'h0) begin bad++; $display("FAIL reset_rden got=%h exp=0", CH_RDEN); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_DATA !== 12'h0 || OUT_CHAN !== 4'h0 || OUT_LAST !== 1'b0)
            begin bad++; $display("FAIL reset_outregs got=%h/%h/%b exp=0/0/0", OUT_DATA, OUT_CHAN, OUT_LAST); end
        total++; if (BUSY !== 1'b0 || ERR !== 1'b0) begin bad++; $display("FAIL reset_busy_err got=%b/%b exp=0/0", BUSY, ERR); end
        rst_n = 1'b1;
        RUN = 1'b1;
        step(5);
        total++; if (BUSY !== 1'b0 || ROREQUEST !== 4'h0)
            begin bad++; $display("FAIL idle_no_trigger busy=%b req=%h exp=0/0", BUSY, ROREQUEST); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_ord [4] = '{0, 1, 3, 0};
        int exp_base;
        clear_mon();
        load_fifo(0, 12'h000, 32);
        load_fifo(1, 12'h200, 16);
        load_fifo(3, 12'h300, 16);
        CH_TRIGGERED = 4'b1011;
        wait_pulses(4, 600, ok);
        CH_TRIGGERED = 4'h0;
        step(10);
        total++; if (!ok) begin bad++; $display("FAIL rr_wait got=%0d pulses exp=4", pulse_tot); end
        total++; if (pulse_tot !== 4) begin bad++; $display("FAIL rr_pulses got=%0d exp=4", pulse_tot); end
        for (int i = 0; i < 4; i++) begin
            total++; if (done_order[i[3:0]] !== exp_ord[i[1:0]])
                begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, done_order[i[3:0]], exp_ord[i[1:0]]); end
        end
        total++; if (cap_n !== 64) begin bad++; $display("FAIL rr_words got=%0d exp=64", cap_n); end
        for (int i = 0; i < 64 && i < cap_n; i++) begin
            case (i / 16)
                0: exp_base = 12'h000;
                1: exp_base = 12'h200;
                2: exp_base = 12'h300;
                default: exp_base = 12'h010;
            endcase
            total++; if (cap_data[i[6:0]] !== 12'(exp_base + i % 16) || cap_chan[i[6:0]] !== 4'(exp_ord[(i / 16) % 4]) ||
                         cap_last[i[6:0]] !== (i % 16 == 15))
                begin bad++; $display("FAIL rr_word[%0d] got=%h/ch%0d/l%b exp=%h/ch%0d/l%b", i, cap_data[i[6:0]],
                      cap_chan[i[6:0]], cap_last[i[6:0]], 12'(exp_base + i % 16), exp_ord[(i / 16) % 4], (i % 16 == 15)); end
        end
        total++; if (low_cyc[0] !== 2 || low_cyc[1] !== 1 || low_cyc[3] !== 1 || low_cyc[2] !== 0)
            begin bad++; $display("FAIL rr_done_cycles got=%0d,%0d,%0d,%0d exp=2,1,0,1", low_cyc[0], low_cyc[1], low_cyc[2], low_cyc[3]); end
        total++; if (oh_viol !== 0) begin bad++; $display("FAIL rr_onehot got=%0d exp=0", oh_viol); end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        load_fifo(2, 12'h100, 16);
        CH_TRIGGERED = 4'b0100;
        step(1);
        CH_TRIGGERED = 4'h0;
        wait_pulses(1, 200, ok);
        step(5);
        total++; if (!ok) begin bad++; $display("FAIL single_wait got=%0d pulses exp=1", pulse_tot); end
        total++; if (cap_n !== 16) begin bad++; $display("FAIL single_words got=%0d exp=16", cap_n); end
        for (int i = 0; i < 16 && i < cap_n; i++) begin
            total++; if (cap_data[i[6:0]] !== 12'(12'h100 + i) || cap_chan[i[6:0]] !== 4'd2 ||
                         cap_last[i[6:0]] !== (i == 15) || cap_cyc[i[6:0]] !== cap_cyc[0] + i)
                begin bad++; $display("FAIL single_word[%0d] got=%h/ch%0d/l%b/c%0d exp=%h/ch2/l%b/c%0d", i, cap_data[i[6:0]],
                      cap_chan[i[6:0]], cap_last[i[6:0]], cap_cyc[i[6:0]], 12'(12'h100 + i), (i == 15), cap_cyc[0] + i); end
        end
        total++; if (low_cyc[2] !== 1 || pulses[2] !== 1)
            begin bad++; $display("FAIL single_rodone got=%0d cycles/%0d pulses exp=1/1", low_cyc[2], pulses[2]); end
        total++; if (req_cyc[2] !== 2) begin bad++; $display("FAIL single_req_cycles got=%0d exp=2", req_cyc[2]); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b exp=0", BUSY); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        load_fifo(1, 12'h400, 16);
        CH_TRIGGERED = 4'b0010;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            step(1);
            CH_TRIGGERED = 4'h0;
            OUT_READY = (k % 4 == 0) || (k % 4 == 3);
            if (pulse_tot >= 1) begin ok = 1'b1; break; end
        end
        OUT_READY = 1'b1;
        step(5);
        total++; if (!ok) begin bad++; $display("FAIL bp_wait got=%0d pulses exp=1", pulse_tot); end
        total++; if (cap_n !== 16) begin bad++; $display("FAIL bp_words got=%0d exp=16", cap_n); end
        for (int i = 0; i < 16 && i < cap_n; i++) begin
            total++; if (cap_data[i[6:0]] !== 12'(12'h400 + i) || cap_chan[i[6:0]] !== 4'd1 || cap_last[i[6:0]] !== (i == 15))
                begin bad++; $display("FAIL bp_word[%0d] got=%h/ch%0d/l%b exp=%h/ch1/l%b", i, cap_data[i[6:0]],
                      cap_chan[i[6:0]], cap_last[i[6:0]], 12'(12'h400 + i), (i == 15)); end
        end
        total++; if (rden_viol !== 0) begin bad++; $display("FAIL bp_rden_while_stalled got=%0d exp=0", rden_viol); end
        total++; if (stab_viol !== 0) begin bad++; $display("FAIL bp_stall_stable got=%0d exp=0", stab_viol); end
    endtask

    task automatic test_underrun();
        bit ok;
        clear_mon();
        load_fifo(0, 12'h600, 5);
        CH_TRIGGERED = 4'b0001;
        step(1);
        CH_TRIGGERED = 4'h0;
        wait_cap(5, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL ur_first5 got=%0d words exp=5", cap_n); end
        step(40);
        total++; if (cap_n !== 5 || BUSY !== 1'b1 || CH_RDEN !== 4'h0)
            begin bad++; $display("FAIL ur_paused got=%0d/%b/%h exp=5/1/0", cap_n, BUSY, CH_RDEN); end
        load_fifo(0, 12'h605, 11);
        wait_pulses(1, 200, ok);
        step(5);
        total++; if (!ok) begin bad++; $display("FAIL ur_wait got=%0d pulses exp=1", pulse_tot); end
        total++; if (cap_n !== 16) begin bad++; $display("FAIL ur_words got=%0d exp=16", cap_n); end
        for (int i = 0; i < 16 && i < cap_n; i++) begin
            total++; if (cap_data[i[6:0]] !== 12'(12'h600 + i) || cap_chan[i[6:0]] !== 4'd0 || cap_last[i[6:0]] !== (i == 15))
                begin bad++; $display("FAIL ur_word[%0d] got=%h/ch%0d/l%b exp=%h/ch0/l%b", i, cap_data[i[6:0]],
                      cap_chan[i[6:0]], cap_last[i[6:0]], 12'(12'h600 + i), (i == 15)); end
        end
        total++; if (cap_n >= 6 && cap_cyc[5] - cap_cyc[4] < 40)
            begin bad++; $display("FAIL ur_gap got=%0d exp>=40", cap_cyc[5] - cap_cyc[4]); end
        total++; if (ERR !== 1'b0) begin bad++; $display("FAIL ur_err got=%b exp=0", ERR); end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_mon();
        resp_en = 4'b1011;
        load_fifo(3, 12'h500, 16);
        CH_TRIGGERED = 4'b1100;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (ROREQUEST[3]) begin ok = 1'b1; break; end
        end
        CH_TRIGGERED = 4'h0;
        total++; if (!ok) begin bad++; $display("FAIL to_next_req got=%h exp=8", ROREQUEST); end
        total++; if (req_cyc[2] !== 8) begin bad++; $display("FAIL to_req_cycles got=%0d exp=8", req_cyc[2]); end
        total++; if (ERR !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", ERR); end
        total++; if (cap_n !== 0) begin bad++; $display("FAIL to_no_words got=%0d exp=0", cap_n); end
        wait_pulses(1, 200, ok);
        step(5);
        total++; if (!ok || pulses[3] !== 1 || pulses[2] !== 0)
            begin bad++; $display("FAIL to_pulses got=ch2:%0d ch3:%0d exp=0/1", pulses[2], pulses[3]); end
        total++; if (cap_n !== 16) begin bad++; $display("FAIL to_words got=%0d exp=16", cap_n); end
        for (int i = 0; i < 16 && i < cap_n; i++) begin
            total++; if (cap_data[i[6:0]] !== 12'(12'h500 + i) || cap_chan[i[6:0]] !== 4'd3)
                begin bad++; $display("FAIL to_word[%0d] got=%h/ch%0d exp=%h/ch3", i, cap_data[i[6:0]],
                      cap_chan[i[6:0]], 12'(12'h500 + i)); end
        end
        resp_en = 4'hF;
    endtask

    task automatic test_async_reset();
        bit ok;
        clear_mon();
        load_fifo(3, 12'h700, 16);
        CH_TRIGGERED = 4'b1000;
        step(1);
        CH_TRIGGERED = 4'h0;
        wait_cap(7, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL ar_wait got=%0d words exp=7", cap_n); end
        rst_n = 1'b0;
        #1;
        total++; if (ROREQUEST !== 4'h0 || RODONE_n !== 4'hF || CH_RDEN !== 4'h0)
            begin bad++; $display("FAIL ar_handshake got=%h/%h/%h exp=0/f/0", ROREQUEST, RODONE_n, CH_RDEN); end
        total++; if (OUT_VALID !== 1'b0 || OUT_LAST !== 1'b0 || OUT_DATA !== 12'h0 || OUT_CHAN !== 4'h0)
            begin bad++; $display("FAIL ar_stream got=%b/%b/%h/%h exp=0/0/0/0", OUT_VALID, OUT_LAST, OUT_DATA, OUT_CHAN); end
        total++; if (BUSY !== 1'b0 || ERR !== 1'b0) begin bad++; $display("FAIL ar_busy_err got=%b/%b exp=0/0", BUSY, ERR); end
        step(3);
        rst_n = 1'b1;
        step(20);
        total++; if (BUSY !== 1'b0 || ROREQUEST !== 4'h0 || OUT_VALID !== 1'b0)
            begin bad++; $display("FAIL ar_stays_idle got=%b/%h/%b exp=0/0/0", BUSY, ROREQUEST, OUT_VALID); end
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            pulses[n[1:0]] = 0; low_cyc[n[1:0]] = 0; req_cyc[n[1:0]] = 0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_underrun();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Master side of the per-channel readout handshake: scans channels waiting in TRIGGERED, drives ROREQUEST, drains a fixed-length event from that channel's show-ahead FIFO onto one output stream, then releases the channel with a RODONE_n pulse.
- Sits between the NCH single-channel state machines plus their sample FIFOs and the downstream packetiser/transmit logic.
- Services one channel at a time, in round-robin order.

Parameters:
- NCH, 4, number of channels served (1..16).
- DATA_W, 12, ADC sample width.
- WORDS, 16, samples read per channel per event (≥1).
- TIMEOUT, 255, max cycles waiting for RO_ENABLE or for RO_ENABLE to drop.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RUN  in  1  enables scanning; sampled only in IDLE.
- CH_TRIGGERED  in  NCH  channel n is in TRIGGERED and awaiting readout.
- RO_ENABLE  in  NCH  channel n's state machine is in READOUT.
- ROREQUEST  out  NCH  readout request to channel n; one-hot or zero.
- RODONE_n  out  NCH  active-low readout-complete strobe to channel n.
- CH_EMPTY  in  NCH  FIFO n empty.
- CH_DATA  in  NCH*DATA_W  FIFO n show-ahead data, channel n at bits [n*DATA_W +: DATA_W].
- CH_RDEN  out  NCH  pop FIFO n; one-hot or zero.
- OUT_DATA  out  DATA_W  output sample.
- OUT_CHAN  out  4  channel index of OUT_DATA.
- OUT_LAST  out  1  marks the final (WORDS-th) sample of a channel.
- OUT_VALID  out  1  output word valid.
- OUT_READY  in  1  downstream accepts the word when OUT_VALID & OUT_READY.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ROREQUEST=0, CH_RDEN=0, RODONE_n=all 1s, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, OUT_CHAN=0, BUSY=0, ERR=0.
  - Round-robin pointer=0; word and timeout counters=0.
  - Reset mid-readout abandons the event. The channel sees ROREQUEST and RODONE_n inactive; its own reset returns it to IDLE.
- IDLE:
  - If RUN and any CH_TRIGGERED bit is set, pick the first set bit at or after the pointer, wrapping modulo NCH.
  - Latch it as cur, then go to REQUEST.
- REQUEST:
  - ROREQUEST[cur]=1, registered.
  - When RO_ENABLE[cur]=1: drop ROREQUEST next cycle and go to READ.
  - If TIMEOUT cycles elapse without RO_ENABLE[cur]: drop ROREQUEST, set ERR, go to NEXT.
- READ:
  - CH_RDEN[cur] is combinational: it equals !CH_EMPTY[cur] & (!OUT_VALID | OUT_READY) & (count<WORDS).
  - Each pop does the following on the same edge:
    - loads OUT_DATA=CH_DATA[cur];
    - sets OUT_CHAN=cur and OUT_VALID=1;
    - sets OUT_LAST=(count==WORDS-1);
    - increments count.
  - OUT_VALID clears on OUT_VALID&OUT_READY with no simultaneous pop.
  - OUT_DATA, OUT_CHAN and OUT_LAST hold while OUT_VALID&!OUT_READY.
  - An empty FIFO stalls READ indefinitely (no timeout).
  - Go to DONE once count==WORDS and the LAST word has been accepted (OUT_VALID & OUT_READY & OUT_LAST).
- DONE:
  - RODONE_n[cur]=0 for exactly one cycle, then go to DRAIN.
- DRAIN:
  - Wait for RO_ENABLE[cur]=0, then go to NEXT.
  - If TIMEOUT cycles elapse first, set ERR and go to NEXT.
- NEXT:
  - pointer=(cur+1) mod NCH; count=0; go to IDLE.
  - NEXT takes one cycle, so back-to-back channels see ≥2 idle cycles between RODONE_n and the next ROREQUEST.
- Invariants:
  - Only cur's bit of ROREQUEST, RODONE_n or CH_RDEN is ever active.
  - ROREQUEST and RODONE_n are never active together.
  - Every output except CH_RDEN is registered.
- Counters:
  - count uses clog2(WORDS+1) bits.
  - Timeout counter uses clog2(TIMEOUT+1) bits and resets on every state entry.
- Boundary cases:
  - RUN deasserted mid-event: the current event still completes; no new event starts.
  - CH_TRIGGERED[cur] dropping after selection is ignored.
  - WORDS=1: the first pop carries OUT_LAST=1.
  - NCH=1: the pointer stays 0.

Test Plan:
- Single event: RUN=1, CH_TRIGGERED=4'b0100; a channel model asserts RO_ENABLE[2] 1 cycle after ROREQUEST[2]; FIFO preloaded with 0x100..0x10F; OUT_READY=1.
  - Expect 16 words 0x100..0x10F, all with OUT_CHAN=2, on consecutive cycles.
  - OUT_LAST only on 0x10F.
  - One-cycle RODONE_n[2]=0, then BUSY=0.
- Round-robin: CH_TRIGGERED=4'b1011 held, pointer=0.
  - Expect channels serviced in order 0, 1, 3, then 0 again.
  - Each gets exactly 16 words and one RODONE_n pulse.
- Backpressure: OUT_READY toggles 1,0,0,1 repeating during a ch1 event.
  - No word lost or duplicated; OUT_DATA stable while stalled.
  - Exactly 16 accepted words.
  - CH_RDEN[1] never high while OUT_VALID&!OUT_READY.
- FIFO underrun: CH_EMPTY[0]=1 for 40 cycles after the 5th word.
  - Stream pauses, then resumes with word 6.
  - ERR stays 0.
- Request timeout (TIMEOUT=8): the channel never raises RO_ENABLE.
  - ROREQUEST drops after 8 cycles, ERR=1, no output words.
  - The next triggered channel is serviced normally.
- Async reset: rst_n=0 after word 7 of a ch3 event.
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - After release with CH_TRIGGERED=0, the block stays in IDLE.
